pac_chek_param: RTL and testbench
=================================

# pac_chek_param

Parametrised successor to the receive-side packet checker in the UART VLC link. It validates incrementing-pattern test frames of configurable word width and length, and frames each packet explicitly on the start-of-frame flag. A gap watchdog closes stalled frames. It reports per-frame results as a registered pulse and keeps saturating, clearable cumulative statistics for the BER/frame-loss readout.

## Interface
- DATA_W, 32: data word width, ≥1.
- FRAME_LEN, 40: words per frame, 1..2^CNT_W-1.
- SEED, 0: expected value of word 0; word k expects (SEED+k) mod 2^DATA_W.
- CNT_W, 32: width of all counters and outputs.
- TIMEOUT, 1024: consecutive no-valid cycles in DATA that abort a frame; 0 disables the watchdog.

Ports:
- i_pac_chek_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_pac_chek_data  in  DATA_W  received word.
- i_pac_chek_data_valid  in  1  word qualifier; a beat is one cycle with valid=1.
- i_pac_chek_sof  in  1  marks a beat as word 0; ignored when valid=0.
- i_stat_clr  in  1  synchronous clear of the cumulative counters.
- o_good_word_num  out  CNT_W  matching words in the current or last frame.
- o_frame_num  out  CNT_W  frames started.
- o_good_frame_num  out  CNT_W  frames ended with all FRAME_LEN words matching.
- o_bad_frame_num  out  CNT_W  frames ended any other way.
- o_timeout_num  out  CNT_W  frames ended by the watchdog.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_frame_good  out  1  frame verdict, valid only while o_frame_done=1.
- o_busy  out  1  high in state DATA.

## Operation
- FSM states are IDLE and DATA. The reset state is IDLE.
- IDLE:
  - A beat with sof=1 starts a frame. It is word 0: index←1, good_word←(data==SEED), frame_num++.
  - If FRAME_LEN=1 that beat also ends the frame and the FSM stays in IDLE. Otherwise the FSM goes to DATA.
  - Beats without sof are discarded.
- DATA:
  - Each beat without sof is compared with SEED+index. good_word increments on a match, and index increments.
  - The beat with index=FRAME_LEN-1 ends the frame and the FSM goes to IDLE.
- Frame verdict: the frame is good iff it ended on length and good_word=FRAME_LEN (good_word counted including the last beat).
- Abort on sof in DATA:
  - The current frame ends with good=0, bad_frame_num++.
  - The same beat starts a new frame as word 0, with frame_num++. The FSM stays in DATA, or goes to IDLE if FRAME_LEN=1.
- Watchdog:
  - The gap counter clears on every beat and when entering DATA, and increments on each DATA cycle with valid=0.
  - When it reaches TIMEOUT, the frame ends with good=0, bad_frame_num++, timeout_num++, and the FSM goes to IDLE.
- o_good_word_num holds its value after a frame ends, until the next sof beat reloads it.
- The comparison is a full DATA_W equality. The expected value wraps mod 2^DATA_W.
- Cumulative counters saturate at all-ones and never wrap.
- i_stat_clr zeroes frame_num, good_frame_num, bad_frame_num and timeout_num. Clear wins over a simultaneous increment. It does not affect the FSM, the index, o_good_word_num, or the done pulse.

## Timing
- All outputs are registered. On reset every output is 0, the state is IDLE, and the index and gap counter are 0.
- Assertion of reset mid-frame discards the frame. No done pulse is produced and no counter is incremented.
- Latency: o_frame_done, o_frame_good and the counter updates appear in the cycle after the ending beat (or after the TIMEOUT-th empty cycle). o_frame_num and o_good_word_num update in the cycle after the sof beat.
- Back-to-back frames are supported: a sof beat in the cycle immediately after the last beat starts the next frame with no loss.
- On an abort, the done pulse (good=0) and the start of the new frame occur on the same edge.
- Valid may have any gaps shorter than TIMEOUT cycles.

## Test plan
- Contiguous sof+words 0..39 (defaults) -> o_frame_done for exactly 1 cycle, one cycle after word 39, with o_frame_good=1. Afterwards good_word=40, frame_num=1, good_frame_num=1, bad_frame_num=0.
- Same frame with word 17 = 0xDEAD -> done with good=0, good_word=39, bad_frame_num=1.
- sof asserted at word 20 of a frame, followed by a full clean frame -> first done has good=0, second done has good=1. End state: frame_num=2, good_frame_num=1, bad_frame_num=1.
- TIMEOUT=16, 10 beats then valid held low -> done with good=0 in the cycle after the 16th empty cycle. timeout_num=1, o_busy=0. A new sof then yields a clean frame.
- Valid every 3rd cycle, DATA_W=8, SEED=250 (expected values wrap 255→0) -> good=1, no timeout. i_stat_clr pulsed in the same cycle as that done -> all cumulative counters read 0.
- CNT_W=4, 20 clean frames -> frame_num=good_frame_num=15 (saturated). Reset asserted at word 5 of a 21st frame -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/pac_chek_param_if.sv
// Receive-side word stream feeding the packet checker: data word, qualifier and start-of-frame flag.
interface pac_chek_param_if #(
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              sof;

  modport master (output data, output data_valid, output sof);
  modport slave  (input data, input data_valid, input sof);
endinterface

// File: rtl/pac_chek_param.sv
// Incrementing-pattern frame checker: sof-framed, gap watchdog, registered per-frame verdict pulse
// and saturating clearable statistics.
module pac_chek_param #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       FRAME_LEN = 40,
  parameter logic [DATA_W-1:0] SEED      = '0,
  parameter int unsigned       CNT_W     = 32,
  parameter int unsigned       TIMEOUT   = 1024
) (
  input  logic             i_pac_chek_clk,
  input  logic             i_rst_n,
  pac_chek_param_if.slave  pac_chek,
  input  logic             i_stat_clr,
  output logic [CNT_W-1:0] o_good_word_num,
  output logic [CNT_W-1:0] o_frame_num,
  output logic [CNT_W-1:0] o_good_frame_num,
  output logic [CNT_W-1:0] o_bad_frame_num,
  output logic [CNT_W-1:0] o_timeout_num,
  output logic             o_frame_done,
  output logic             o_frame_good,
  output logic             o_busy
);

  localparam int unsigned SumW = (DATA_W > CNT_W) ? DATA_W : CNT_W;
  localparam int unsigned GapW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LastIdx  = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] FullCnt  = CNT_W'(FRAME_LEN);
  localparam logic [GapW-1:0]  GapLimit = GapW'(TIMEOUT);

  typedef enum logic [0:0] {StIdle, StData} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] index_q, index_d;
  logic [GapW-1:0]  gap_q, gap_d;
  logic [CNT_W-1:0] good_word_q, good_word_d;
  logic [CNT_W-1:0] frame_num_q, frame_num_d;
  logic [CNT_W-1:0] good_frame_q, good_frame_d;
  logic [CNT_W-1:0] bad_frame_q, bad_frame_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic             done_q, done_d;
  logic             good_q, good_d;

  logic              beat;
  logic              sof_beat;
  logic [SumW-1:0]   exp_sum;
  logic [DATA_W-1:0] exp_word;
  logic              word_match;
  logic              seed_match;
  logic              frame_start;
  logic              end_good;
  logic              end_bad;
  logic              end_timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign beat     = pac_chek.data_valid;
  assign sof_beat = beat & pac_chek.sof;

  // Expected word wraps modulo 2^DATA_W regardless of which of DATA_W/CNT_W is wider.
  always_comb begin
    exp_sum    = SumW'(SEED) + SumW'(index_q);
    exp_word   = exp_sum[DATA_W-1:0];
    word_match = (pac_chek.data == exp_word);
    seed_match = (pac_chek.data == SEED);
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    gap_d       = gap_q;
    good_word_d = good_word_q;
    frame_start = 1'b0;
    end_good    = 1'b0;
    end_bad     = 1'b0;
    end_timeout = 1'b0;

    if (sof_beat) begin
      // A sof beat in DATA aborts the running frame and is word 0 of the next one.
      frame_start = 1'b1;
      end_bad     = (state_q == StData);
      index_d     = CNT_W'(1);
      good_word_d = CNT_W'(seed_match);
      gap_d       = '0;
      if (FRAME_LEN == 1) begin
        index_d = '0;
        state_d = StIdle;
        if (seed_match) begin
          end_good = 1'b1;
        end else begin
          end_bad = 1'b1;
        end
      end else begin
        state_d = StData;
      end
    end else if (state_q == StData) begin
      if (beat) begin
        gap_d       = '0;
        good_word_d = good_word_q + CNT_W'(word_match);
        if (index_q == LastIdx) begin
          index_d = '0;
          state_d = StIdle;
          if (good_word_d == FullCnt) begin
            end_good = 1'b1;
          end else begin
            end_bad = 1'b1;
          end
        end else begin
          index_d = index_q + CNT_W'(1);
        end
      end else if (TIMEOUT != 0) begin
        gap_d = gap_q + GapW'(1);
        if (gap_d == GapLimit) begin
          gap_d       = '0;
          index_d     = '0;
          state_d     = StIdle;
          end_bad     = 1'b1;
          end_timeout = 1'b1;
        end
      end
    end
  end

  // Clear has priority over a same-cycle increment.
  always_comb begin
    frame_num_d  = frame_num_q;
    good_frame_d = good_frame_q;
    bad_frame_d  = bad_frame_q;
    timeout_d    = timeout_q;
    if (i_stat_clr) begin
      frame_num_d  = '0;
      good_frame_d = '0;
      bad_frame_d  = '0;
      timeout_d    = '0;
    end else begin
      if (frame_start) begin
        frame_num_d = sat_inc(frame_num_q);
      end
      if (end_good) begin
        good_frame_d = sat_inc(good_frame_q);
      end
      if (end_bad) begin
        bad_frame_d = sat_inc(bad_frame_q);
      end
      if (end_timeout) begin
        timeout_d = sat_inc(timeout_q);
      end
    end
    done_d = end_good | end_bad;
    good_d = end_good;
  end

  always_ff @(posedge i_pac_chek_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      index_q      <= '0;
      gap_q        <= '0;
      good_word_q  <= '0;
      frame_num_q  <= '0;
      good_frame_q <= '0;
      bad_frame_q  <= '0;
      timeout_q    <= '0;
      done_q       <= 1'b0;
      good_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      gap_q        <= gap_d;
      good_word_q  <= good_word_d;
      frame_num_q  <= frame_num_d;
      good_frame_q <= good_frame_d;
      bad_frame_q  <= bad_frame_d;
      timeout_q    <= timeout_d;
      done_q       <= done_d;
      good_q       <= good_d;
    end
  end

  assign o_good_word_num  = good_word_q;
  assign o_frame_num      = frame_num_q;
  assign o_good_frame_num = good_frame_q;
  assign o_bad_frame_num  = bad_frame_q;
  assign o_timeout_num    = timeout_q;
  assign o_frame_done     = done_q;
  assign o_frame_good     = good_q;
  assign o_busy           = (state_q == StData);

  a_good_implies_done: assert property (@(posedge i_pac_chek_clk) disable iff (!i_rst_n)
    o_frame_good |-> o_frame_done);
  a_single_verdict: assert property (@(posedge i_pac_chek_clk) disable iff (!i_rst_n)
    !(end_good && end_bad));

endmodule

// File: tb/tb_pac_chek_param.sv
// Directed bench for pac_chek_param: three parameterisations sharing one clock.
module tb_pac_chek_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b_n = 1'b0;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic clr_c = 1'b0;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt_b = 0;

  // A: default frame, 16-cycle watchdog
  pac_chek_param_if #(.DATA_W(32)) if_a();
  logic [31:0] gw_a, fn_a, gf_a, bf_a, to_a;
  logic        done_a, good_a, busy_a;

  pac_chek_param #(
    .DATA_W(32), .FRAME_LEN(40), .SEED(32'd0), .CNT_W(32), .TIMEOUT(16)
  ) u_a (
    .i_pac_chek_clk(clk), .i_rst_n(rst_n), .pac_chek(if_a), .i_stat_clr(clr_a),
    .o_good_word_num(gw_a), .o_frame_num(fn_a), .o_good_frame_num(gf_a),
    .o_bad_frame_num(bf_a), .o_timeout_num(to_a), .o_frame_done(done_a),
    .o_frame_good(good_a), .o_busy(busy_a)
  );

  // B: 8-bit wrapping pattern, 4-bit saturating counters
  pac_chek_param_if #(.DATA_W(8)) if_b();
  logic [3:0] gw_b, fn_b, gf_b, bf_b, to_b;
  logic       done_b, good_b, busy_b;

  pac_chek_param #(
    .DATA_W(8), .FRAME_LEN(10), .SEED(8'd250), .CNT_W(4), .TIMEOUT(16)
  ) u_b (
    .i_pac_chek_clk(clk), .i_rst_n(rst_b_n), .pac_chek(if_b), .i_stat_clr(clr_b),
    .o_good_word_num(gw_b), .o_frame_num(fn_b), .o_good_frame_num(gf_b),
    .o_bad_frame_num(bf_b), .o_timeout_num(to_b), .o_frame_done(done_b),
    .o_frame_good(good_b), .o_busy(busy_b)
  );

  // C: single-word frames, watchdog disabled
  pac_chek_param_if #(.DATA_W(8)) if_c();
  logic [7:0] gw_c, fn_c, gf_c, bf_c, to_c;
  logic       done_c, good_c, busy_c;

  pac_chek_param #(
    .DATA_W(8), .FRAME_LEN(1), .SEED(8'd5), .CNT_W(8), .TIMEOUT(0)
  ) u_c (
    .i_pac_chek_clk(clk), .i_rst_n(rst_n), .pac_chek(if_c), .i_stat_clr(clr_c),
    .o_good_word_num(gw_c), .o_frame_num(fn_c), .o_good_frame_num(gf_c),
    .o_bad_frame_num(bf_c), .o_timeout_num(to_c), .o_frame_done(done_c),
    .o_frame_good(good_c), .o_busy(busy_c)
  );

  always @(posedge clk) begin
    if (done_b) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic a_beat(input logic [31:0] d, input logic s);
    @(negedge clk);
    if_a.data = d; if_a.data_valid = 1'b1; if_a.sof = s;
  endtask

  task automatic a_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if_a.data_valid = 1'b0; if_a.sof = 1'b0;
    end
  endtask

  task automatic a_frame(input int bad_at, input logic [31:0] bad_val);
    for (int k = 0; k < 40; k++) a_beat((k == bad_at) ? bad_val : 32'(k), k == 0);
  endtask

  task automatic b_beat(input logic [7:0] d, input logic s);
    @(negedge clk);
    if_b.data = d; if_b.data_valid = 1'b1; if_b.sof = s;
  endtask

  task automatic b_idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if_b.data_valid = 1'b0; if_b.sof = 1'b0;
    end
  endtask

  task automatic c_beat(input logic [7:0] d, input logic s);
    @(negedge clk);
    if_c.data = d; if_c.data_valid = 1'b1; if_c.sof = s;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish within bound");
    $fatal(1);
  end

  initial begin
    if_a.data = '0; if_a.data_valid = 1'b0; if_a.sof = 1'b0;
    if_b.data = '0; if_b.data_valid = 1'b0; if_b.sof = 1'b0;
    if_c.data = '0; if_c.data_valid = 1'b0; if_c.sof = 1'b0;
    repeat (2) @(negedge clk);

    check_eq("a_rst_done", 64'(done_a), 0);
    check_eq("a_rst_gw", 64'(gw_a), 0);
    check_eq("a_rst_fn", 64'(fn_a), 0);
    check_eq("a_rst_busy", 64'(busy_a), 0);
    check_eq("b_rst_fn", 64'(fn_b), 0);
    rst_n = 1'b1;
    rst_b_n = 1'b1;

    // Clean contiguous frame
    a_frame(-1, 32'd0);
    a_idle(1);
    check_eq("a_clean_done", 64'(done_a), 1);
    check_eq("a_clean_good", 64'(good_a), 1);
    check_eq("a_clean_gw", 64'(gw_a), 40);
    check_eq("a_clean_fn", 64'(fn_a), 1);
    check_eq("a_clean_gf", 64'(gf_a), 1);
    check_eq("a_clean_bf", 64'(bf_a), 0);
    check_eq("a_clean_busy", 64'(busy_a), 0);
    a_idle(1);
    check_eq("a_done_width", 64'(done_a), 0);

    // Corrupted word 17
    a_frame(17, 32'hDEAD);
    a_idle(1);
    check_eq("a_bad_done", 64'(done_a), 1);
    check_eq("a_bad_good", 64'(good_a), 0);
    check_eq("a_bad_gw", 64'(gw_a), 39);
    check_eq("a_bad_bf", 64'(bf_a), 1);
    check_eq("a_bad_fn", 64'(fn_a), 2);

    // Statistics clear leaves good_word untouched
    @(negedge clk); clr_a = 1'b1;
    @(negedge clk); clr_a = 1'b0;
    check_eq("a_clr_fn", 64'(fn_a), 0);
    check_eq("a_clr_bf", 64'(bf_a), 0);
    check_eq("a_clr_gf", 64'(gf_a), 0);
    check_eq("a_clr_gw", 64'(gw_a), 39);

    // sof at word 20 aborts, then a full clean frame
    for (int k = 0; k < 20; k++) a_beat(32'(k), k == 0);
    a_beat(32'd0, 1'b1);
    a_beat(32'd1, 1'b0);
    check_eq("a_abort_done", 64'(done_a), 1);
    check_eq("a_abort_good", 64'(good_a), 0);
    check_eq("a_abort_busy", 64'(busy_a), 1);
    check_eq("a_abort_fn", 64'(fn_a), 2);
    check_eq("a_abort_gw", 64'(gw_a), 1);
    for (int k = 2; k < 40; k++) a_beat(32'(k), 1'b0);
    a_idle(1);
    check_eq("a_after_abort_done", 64'(done_a), 1);
    check_eq("a_after_abort_good", 64'(good_a), 1);
    check_eq("a_after_abort_fn", 64'(fn_a), 2);
    check_eq("a_after_abort_gf", 64'(gf_a), 1);
    check_eq("a_after_abort_bf", 64'(bf_a), 1);

    // Watchdog: 10 beats then silence
    for (int k = 0; k < 10; k++) a_beat(32'(k), k == 0);
    a_idle(16);
    check_eq("a_to_early_done", 64'(done_a), 0);
    check_eq("a_to_early_busy", 64'(busy_a), 1);
    a_idle(1);
    check_eq("a_to_done", 64'(done_a), 1);
    check_eq("a_to_good", 64'(good_a), 0);
    check_eq("a_to_busy", 64'(busy_a), 0);
    check_eq("a_to_cnt", 64'(to_a), 1);
    check_eq("a_to_bf", 64'(bf_a), 2);
    a_frame(-1, 32'd0);
    a_idle(1);
    check_eq("a_post_to_good", 64'(good_a), 1);
    check_eq("a_post_to_gf", 64'(gf_a), 2);

    // B: sparse beats with wrapping pattern; clear coincides with the last beat
    for (int k = 0; k < 9; k++) begin
      b_beat(8'(250 + k), k == 0);
      b_idle(2);
    end
    @(negedge clk);
    if_b.data = 8'd3; if_b.data_valid = 1'b1; if_b.sof = 1'b0; clr_b = 1'b1;
    b_idle(1);
    clr_b = 1'b0;
    check_eq("b_wrap_done", 64'(done_b), 1);
    check_eq("b_wrap_good", 64'(good_b), 1);
    check_eq("b_wrap_gw", 64'(gw_b), 10);
    check_eq("b_clr_fn", 64'(fn_b), 0);
    check_eq("b_clr_gf", 64'(gf_b), 0);
    check_eq("b_clr_bf", 64'(bf_b), 0);
    check_eq("b_clr_to", 64'(to_b), 0);

    // B: 20 back-to-back frames saturate the 4-bit counters
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < 10; k++) b_beat(8'(250 + k), k == 0);
    end
    b_idle(1);
    check_eq("b_sat_good", 64'(good_b), 1);
    check_eq("b_sat_fn", 64'(fn_b), 15);
    check_eq("b_sat_gf", 64'(gf_b), 15);
    check_eq("b_sat_bf", 64'(bf_b), 0);
    b_idle(1);
    check_eq("b_done_count", 64'(done_cnt_b), 21);

    // B: reset at word 5 of frame 21
    for (int k = 0; k < 5; k++) b_beat(8'(250 + k), k == 0);
    @(negedge clk);
    if_b.data = 8'd255; if_b.data_valid = 1'b1; if_b.sof = 1'b0; rst_b_n = 1'b0;
    #1;
    check_eq("b_rst_gw", 64'(gw_b), 0);
    check_eq("b_rst_fn2", 64'(fn_b), 0);
    check_eq("b_rst_gf", 64'(gf_b), 0);
    check_eq("b_rst_bf", 64'(bf_b), 0);
    check_eq("b_rst_to", 64'(to_b), 0);
    check_eq("b_rst_done", 64'(done_b), 0);
    check_eq("b_rst_good", 64'(good_b), 0);
    check_eq("b_rst_busy", 64'(busy_b), 0);
    b_idle(2);
    rst_b_n = 1'b1;
    b_idle(3);
    check_eq("b_rst_no_done", 64'(done_cnt_b), 21);

    // C: single-word frames, non-sof beat discarded
    c_beat(8'd5, 1'b1);
    c_beat(8'd5, 1'b0);
    check_eq("c_one_done", 64'(done_c), 1);
    check_eq("c_one_good", 64'(good_c), 1);
    check_eq("c_one_fn", 64'(fn_c), 1);
    check_eq("c_one_gw", 64'(gw_c), 1);
    check_eq("c_one_busy", 64'(busy_c), 0);
    c_beat(8'd6, 1'b1);
    check_eq("c_discard_done", 64'(done_c), 0);
    check_eq("c_discard_fn", 64'(fn_c), 1);
    @(negedge clk);
    if_c.data_valid = 1'b0; if_c.sof = 1'b0;
    check_eq("c_bad_done", 64'(done_c), 1);
    check_eq("c_bad_good", 64'(good_c), 0);
    check_eq("c_bad_fn", 64'(fn_c), 2);
    check_eq("c_bad_bf", 64'(bf_c), 1);
    check_eq("c_bad_gw", 64'(gw_c), 0);
    check_eq("c_bad_gf", 64'(gf_c), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
